// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers the decoded bundle, forwards from MEM/WB,
// selects ALU operands and inserts a single bubble on load-use hazards.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            in_uses_rs1,
    input  logic            in_uses_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_a_sel,
    input  logic            in_b_sel,
    input  logic [3:0]      in_ctrl,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic            mem_rd_we,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_result,
    output logic            out_valid,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [3:0]      ctrl,
    output logic [XLEN-1:0] rs2_val,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_rd_we,
    output logic            out_is_load,
    output logic            hazard
);

    logic            valid_q;
    logic [RA_W-1:0] rs1_addr_q;
    logic [RA_W-1:0] rs2_addr_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic            a_sel_q;
    logic            b_sel_q;
    logic [3:0]      ctrl_q;
    logic [RA_W-1:0] rd_addr_q;
    logic            rd_we_q;
    logic            is_load_q;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            rs1_match;
    logic            rs2_match;

    assign out_valid   = valid_q;
    assign out_rd_addr = rd_addr_q;
    assign out_rd_we   = valid_q & rd_we_q;
    assign out_is_load = valid_q & is_load_q;
    assign ctrl        = valid_q ? ctrl_q : 4'b0000;

    // A consumer of the held load cannot enter until the load reaches MEM.
    assign rs1_match = in_uses_rs1 && (in_rs1_addr == rd_addr_q);
    assign rs2_match = in_uses_rs2 && (in_rs2_addr == rd_addr_q);
    assign hazard    = in_valid & out_is_load & out_rd_we & (rd_addr_q != '0)
                     & (rs1_match | rs2_match);
    assign in_ready  = ~ex_stall & ~hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            ctrl_q     <= 4'b0000;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rd_we_q <= 1'b0;
        end else if (!ex_stall) begin
            if (hazard) begin
                valid_q   <= 1'b0;
                rd_we_q   <= 1'b0;
                is_load_q <= 1'b0;
            end else if (in_valid) begin
                valid_q    <= 1'b1;
                rs1_addr_q <= in_rs1_addr;
                rs2_addr_q <= in_rs2_addr;
                rs1_data_q <= in_rs1_data;
                rs2_data_q <= in_rs2_data;
                imm_q      <= in_imm;
                pc_q       <= in_pc;
                a_sel_q    <= in_a_sel;
                b_sel_q    <= in_b_sel;
                ctrl_q     <= in_ctrl;
                rd_addr_q  <= in_rd_addr;
                rd_we_q    <= in_rd_we;
                is_load_q  <= in_is_load;
            end else begin
                valid_q <= 1'b0;
                rd_we_q <= 1'b0;
            end
        end
    end

    // MEM wins over WB; a load in MEM has no data yet so it never forwards.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (rs1_addr_q == '0) begin
            fwd_rs1 = rs1_data_q;
        end else if (mem_rd_we && !mem_is_load && (mem_rd_addr == rs1_addr_q)) begin
            fwd_rs1 = mem_result;
        end else if (wb_rd_we && (wb_rd_addr == rs1_addr_q)) begin
            fwd_rs1 = wb_result;
        end
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (rs2_addr_q == '0) begin
            fwd_rs2 = rs2_data_q;
        end else if (mem_rd_we && !mem_is_load && (mem_rd_addr == rs2_addr_q)) begin
            fwd_rs2 = mem_result;
        end else if (wb_rd_we && (wb_rd_addr == rs2_addr_q)) begin
            fwd_rs2 = wb_result;
        end
    end

    assign a       = a_sel_q ? pc_q : fwd_rs1;
    assign b       = b_sel_q ? imm_q : fwd_rs2;
    assign rs2_val = fwd_rs2;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, capture, forwarding,
// load-use bubble, operand select, flush and stall.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        in_uses_rs1;
    logic        in_uses_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic        in_a_sel;
    logic        in_b_sel;
    logic [3:0]  in_ctrl;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic        in_is_load;
    logic        flush;
    logic        ex_stall;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic        mem_is_load;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_result;
    logic        out_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] rs2_val;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic        out_is_load;
    logic        hazard;

    int total = 0;
    int bad   = 0;

    alu_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_ctrl(in_ctrl),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .flush(flush), .ex_stall(ex_stall),
        .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we),
        .mem_is_load(mem_is_load), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_result(wb_result),
        .out_valid(out_valid), .a(a), .b(b), .ctrl(ctrl), .rs2_val(rs2_val),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
        .out_is_load(out_is_load), .hazard(hazard)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        valid,
        input logic [4:0]  rs1a, input logic [31:0] rs1d,
        input logic [4:0]  rs2a, input logic [31:0] rs2d,
        input logic        asel, input logic [31:0] pc,
        input logic        bsel, input logic [31:0] imm,
        input logic [3:0]  op,
        input logic [4:0]  rd, input logic rdwe, input logic isld);
        in_valid    = valid;
        in_rs1_addr = rs1a;
        in_rs1_data = rs1d;
        in_rs2_addr = rs2a;
        in_rs2_data = rs2d;
        in_uses_rs1 = 1'b1;
        in_uses_rs2 = 1'b1;
        in_a_sel    = asel;
        in_pc       = pc;
        in_b_sel    = bsel;
        in_imm      = imm;
        in_ctrl     = op;
        in_rd_addr  = rd;
        in_rd_we    = rdwe;
        in_is_load  = isld;
    endtask

    task automatic clearBuses();
        mem_rd_addr = '0; mem_rd_we = 1'b0; mem_is_load = 1'b0; mem_result = '0;
        wb_rd_addr  = '0; wb_rd_we  = 1'b0; wb_result   = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
        clearBuses();
        applyStimulus(1'b1, 5'd1, 32'h1111, 5'd2, 32'h2222, 1'b0, 32'h40,
                      1'b0, 32'h0, 4'b0011, 5'd3, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_a", a, 32'd0);
        checkOutput("reset_b", b, 32'd0);
        checkOutput("reset_ctrl", {28'b0, ctrl}, 32'd0);
        checkOutput("reset_rd_we", {31'b0, out_rd_we}, 32'd0);
        rst = 1'b0;

        // ADD x3 = x1 + x2
        applyStimulus(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'h0,
                      1'b0, 32'h0, 4'b0000, 5'd3, 1'b1, 1'b0);
        tick();
        checkOutput("add_a", a, 32'd5);
        checkOutput("add_b", b, 32'd7);
        checkOutput("add_ctrl", {28'b0, ctrl}, 32'd0);
        checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("add_rd", {27'b0, out_rd_addr}, 32'd3);
        checkOutput("add_sum", a + b, 32'd12);

        // Forwarding priority on rs1 = x4
        applyStimulus(1'b1, 5'd4, 32'd1, 5'd6, 32'd9, 1'b0, 32'h0,
                      1'b0, 32'h0, 4'b0010, 5'd11, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        mem_rd_addr = 5'd4; mem_rd_we = 1'b1; mem_result = 32'hAA;
        wb_rd_addr  = 5'd4; wb_rd_we  = 1'b1; wb_result  = 32'hBB;
        #1;
        checkOutput("fwd_mem", a, 32'hAA);
        checkOutput("fwd_ctrl", {28'b0, ctrl}, 32'd2);
        checkOutput("fwd_rs2_nomatch", rs2_val, 32'd9);
        mem_rd_we = 1'b0;
        #1;
        checkOutput("fwd_wb", a, 32'hBB);
        mem_rd_we = 1'b1; mem_is_load = 1'b1;
        #1;
        checkOutput("fwd_memload_skip", a, 32'hBB);
        mem_is_load = 1'b0;
        applyStimulus(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'h0,
                      1'b0, 32'h0, 4'b0000, 5'd12, 1'b1, 1'b0);
        mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
        tick();
        checkOutput("fwd_x0", a, 32'd0);
        checkOutput("fwd_x0_rs2", rs2_val, 32'd0);
        clearBuses();

        // Load-use: LW x5 then a consumer of x5
        applyStimulus(1'b1, 5'd1, 32'h10, 5'd0, 32'd0, 1'b0, 32'h0,
                      1'b1, 32'd4, 4'b0000, 5'd5, 1'b1, 1'b1);
        tick();
        checkOutput("lw_is_load", {31'b0, out_is_load}, 32'd1);
        applyStimulus(1'b0, 5'd5, 32'hDEAD, 5'd7, 32'd0, 1'b0, 32'h0,
                      1'b0, 32'h0, 4'b0001, 5'd8, 1'b1, 1'b0);
        #1;
        checkOutput("lu_novalid", {31'b0, hazard}, 32'd0);
        in_valid = 1'b1;
        in_uses_rs1 = 1'b0;
        #1;
        checkOutput("lu_unused_rs1", {31'b0, hazard}, 32'd0);
        in_uses_rs1 = 1'b1;
        #1;
        checkOutput("lu_hazard", {31'b0, hazard}, 32'd1);
        checkOutput("lu_ready", {31'b0, in_ready}, 32'd0);
        tick();
        checkOutput("lu_bubble_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("lu_bubble_load", {31'b0, out_is_load}, 32'd0);
        checkOutput("lu_bubble_ctrl", {28'b0, ctrl}, 32'd0);
        checkOutput("lu_ready_after", {31'b0, in_ready}, 32'd1);
        mem_rd_addr = 5'd5; mem_rd_we = 1'b1; mem_is_load = 1'b1; mem_result = 32'h77;
        tick();
        checkOutput("lu_consumer_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("lu_consumer_ctrl", {28'b0, ctrl}, 32'd1);
        checkOutput("lu_mem_load_nofwd", a, 32'hDEAD);
        mem_rd_addr = 5'd0; mem_rd_we = 1'b0; mem_is_load = 1'b0;
        wb_rd_addr = 5'd5; wb_rd_we = 1'b1; wb_result = 32'h1234;
        #1;
        checkOutput("lu_wb_fwd", a, 32'h1234);
        clearBuses();

        // PC / immediate select
        applyStimulus(1'b1, 5'd1, 32'h9, 5'd2, 32'h55, 1'b1, 32'h100,
                      1'b1, 32'hFFFFFFFC, 4'b0000, 5'd9, 1'b1, 1'b0);
        tick();
        checkOutput("sel_a_pc", a, 32'h100);
        checkOutput("sel_b_imm", b, 32'hFFFFFFFC);
        checkOutput("sel_rs2_val", rs2_val, 32'h55);

        // flush together with stall drops the held and incoming bundles
        applyStimulus(1'b1, 5'd3, 32'h333, 5'd4, 32'h444, 1'b0, 32'h200,
                      1'b0, 32'h0, 4'b0101, 5'd13, 1'b1, 1'b0);
        flush = 1'b1; ex_stall = 1'b1;
        #1;
        checkOutput("flush_ready", {31'b0, in_ready}, 32'd0);
        tick();
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_rd_we", {31'b0, out_rd_we}, 32'd0);
        checkOutput("flush_no_capture", a, 32'h100);
        flush = 1'b0; ex_stall = 1'b0;

        // Stall holds everything for three cycles
        applyStimulus(1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 32'h0,
                      1'b0, 32'h0, 4'b0110, 5'd10, 1'b1, 1'b0);
        tick();
        checkOutput("stall_pre_a", a, 32'h11);
        ex_stall = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'h99, 5'd4, 32'h98, 1'b0, 32'h0,
                      1'b0, 32'h0, 4'b0111, 5'd14, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_a", a, 32'h11);
            checkOutput("stall_b", b, 32'h22);
            checkOutput("stall_ctrl", {28'b0, ctrl}, 32'd6);
            checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_rd", {27'b0, out_rd_addr}, 32'd10);
            checkOutput("stall_ready", {31'b0, in_ready}, 32'd0);
        end
        ex_stall = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("idle_rd_we", {31'b0, out_rd_we}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
